// File: rtl/pico_mips_mc_pkg.sv
// ----------------------------------------------------------------------------
// pico_pkg
// Shared types for the multi-cycle picoMIPS core.
// Contents:
//   OPCODE_W  width of the opcode field at the top of every instruction
//   opcode_t  the eight instruction opcodes
//   state_t   control FSM states
// ----------------------------------------------------------------------------
package pico_pkg;

   localparam int OPCODE_W = 3;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_ADDI = 3'd1,
      OP_MULI = 3'd2,
      OP_SUB  = 3'd3,
      OP_IN   = 3'd4,
      OP_OUT  = 3'd5,
      OP_BZ   = 3'd6,
      OP_JMP  = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      S_FETCH    = 2'd0,
      S_EXEC     = 2'd1,
      S_WAIT_IN  = 2'd2,
      S_WAIT_OUT = 2'd3
   } state_t;

endpackage

// File: rtl/pico_mips_mc_if.sv
// ----------------------------------------------------------------------------
// pico_mips_mc_if
// Bus bundle between the core and its surroundings: program ROM port plus the
// valid/ready IN and OUT channels.
// Signals:
//   imem_addr  core -> ROM   instruction address (the PC)
//   imem_data  ROM  -> core  instruction at imem_addr, combinational read
//   in_data    env  -> core  input channel data
//   in_valid   env  -> core  input data valid
//   in_ready   core -> env   core takes in_data this cycle
//   out_data   core -> env   output channel data
//   out_valid  core -> env   out_data valid, held until accepted
//   out_ready  env  -> core  sink takes out_data
// Modports: master = core side, slave = environment side.
// ----------------------------------------------------------------------------
interface pico_mips_mc_if #(
   parameter int N     = 8,
   parameter int NREGS = 4,
   parameter int Psize = 5,
   localparam int Isize = 3 + 2 * $clog2(NREGS) + N
);
   logic [Psize-1:0] imem_addr;
   logic [Isize-1:0] imem_data;
   logic [N-1:0]     in_data;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output imem_addr, in_ready, out_data, out_valid,
      input  imem_data, in_data, in_valid, out_ready
   );

   modport slave (
      input  imem_addr, in_ready, out_data, out_valid,
      output imem_data, in_data, in_valid, out_ready
   );
endinterface

// File: rtl/pico_mips_mc_regfile.sv
// ----------------------------------------------------------------------------
// pico_regfile
// General-purpose register file: two asynchronous read ports, one synchronous
// write port, synchronous active-low clear of every register.
// Ports:
//   clk      system clock
//   reset    synchronous active-low clear (wins over a write)
//   ra_addr / ra_data   read port A
//   rb_addr / rb_data   read port B
//   we, wa, wd          write enable, address, data
// ----------------------------------------------------------------------------
module pico_regfile #(
   parameter int N     = 8,
   parameter int NREGS = 4,
   localparam int RB   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [RB-1:0] ra_addr,
   output logic [N-1:0]  ra_data,
   input  logic [RB-1:0] rb_addr,
   output logic [N-1:0]  rb_data,
   input  logic          we,
   input  logic [RB-1:0] wa,
   input  logic [N-1:0]  wd
);
   logic [N-1:0] regs_q [NREGS];
   logic [N-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[wa] = wd;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads see the pre-write value, so Rd==Rs instructions use the old Rd.
   assign ra_data = regs_q[ra_addr];
   assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/pico_mips_mc.sv
// ----------------------------------------------------------------------------
// pico_mips_mc
// Multi-cycle picoMIPS core. Each instruction is fetched in one cycle and
// executed in the next; IN and OUT park in a wait state until their channel
// handshake completes.
// Ports:
//   clk     system clock, all state updates on posedge
//   reset   synchronous active-low reset
//   bus     master side of pico_mips_mc_if (ROM port, IN and OUT channels)
//   halted  high while stalled on an IN or OUT handshake
// ----------------------------------------------------------------------------
module pico_mips_mc
   import pico_pkg::*;
#(
   parameter int N     = 8,
   parameter int NREGS = 4,
   parameter int Psize = 5,
   localparam int RB    = $clog2(NREGS),
   localparam int Isize = OPCODE_W + 2 * RB + N
) (
   input  logic           clk,
   input  logic           reset,
   pico_mips_mc_if.master bus,
   output logic           halted
);
   state_t            state_q, state_d;
   logic [Psize-1:0]  pc_q, pc_d;
   logic [Isize-1:0]  ir_q, ir_d;
   logic [N-1:0]      out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;

   opcode_t           opcode;
   logic [RB-1:0]     rd_addr, rs_addr;
   logic [N-1:0]      imm, rd_val, rs_val, alu_res, wr_data;
   logic              wr_en;
   logic [Psize-1:0]  pc_inc, br_target;
   logic signed [2*N-1:0] prod;
   logic              unused_prod_bits;

   assign opcode    = opcode_t'(ir_q[Isize-1 -: OPCODE_W]);
   assign rd_addr   = ir_q[Isize-OPCODE_W-1 -: RB];
   assign rs_addr   = ir_q[Isize-OPCODE_W-RB-1 -: RB];
   assign imm       = ir_q[N-1:0];
   assign pc_inc    = pc_q + Psize'(1);
   assign br_target = imm[Psize-1:0];

   pico_regfile #(.N(N), .NREGS(NREGS)) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .ra_addr (rd_addr),
      .ra_data (rd_val),
      .rb_addr (rs_addr),
      .rb_data (rs_val),
      .we      (wr_en),
      .wa      (rd_addr),
      .wd      (wr_data)
   );

   // Signed Q1.(N-1) multiply: shifting right by N-1 and keeping N bits is
   // just a slice of the full double-width product.
   assign prod             = $signed(rd_val) * $signed(imm);
   assign unused_prod_bits = ^{prod[2*N-1], prod[N-2:0]};

   always_comb begin
      alu_res = rd_val;
      case (opcode)
         OP_ADD:  alu_res = rd_val + rs_val;
         OP_ADDI: alu_res = rd_val + imm;
         OP_MULI: alu_res = prod[2*N-2 -: N];
         OP_SUB:  alu_res = rd_val - rs_val;
         default: alu_res = rd_val;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      wr_en       = 1'b0;
      wr_data     = alu_res;
      case (state_q)
         S_FETCH: begin
            ir_d    = bus.imem_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode)
               OP_ADD, OP_ADDI, OP_MULI, OP_SUB: begin
                  wr_en = 1'b1;
                  pc_d  = pc_inc;
               end
               OP_IN: begin
                  state_d = S_WAIT_IN;
               end
               OP_OUT: begin
                  // Capture Rd on entry so out_data stays stable while waiting.
                  out_data_d  = rd_val;
                  out_valid_d = 1'b1;
                  state_d     = S_WAIT_OUT;
               end
               OP_BZ: begin
                  pc_d = (rd_val == '0) ? br_target : pc_inc;
               end
               default: begin
                  pc_d = br_target;
               end
            endcase
         end
         S_WAIT_IN: begin
            if (bus.in_valid) begin
               wr_en   = 1'b1;
               wr_data = bus.in_data;
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end
         end
         default: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               pc_d        = pc_inc;
               state_d     = S_FETCH;
            end
         end
      endcase
   end

   // Reset abandons any pending handshake because it overrides every update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_FETCH;
         pc_q        <= '0;
         ir_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.in_ready  = (state_q == S_WAIT_IN);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign halted        = (state_q == S_WAIT_IN) || (state_q == S_WAIT_OUT);

endmodule

// File: tb/tb_pico_mips_mc.sv
// ----------------------------------------------------------------------------
// tb_pico_mips_mc
// Bench for pico_mips_mc: directed programs with literal expectations plus
// random programs, all compared every cycle against an instruction-level
// model of the core.
// ----------------------------------------------------------------------------
module tb_pico_mips_mc;
   import pico_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        out_ready = 1'b1;
   logic        halted;
   logic [14:0] rom [32];

   int total = 0;
   int bad = 0;

   // Instruction-level model state
   logic [7:0]  m_regs [4];
   logic [4:0]  m_pc = 5'd0;
   logic [7:0]  exp_out_data = 8'h00;
   logic        exp_out_valid = 1'b0;
   logic        exp_in_ready = 1'b0;
   logic        exp_halted = 1'b0;
   bit          check_en = 1'b0;

   pico_mips_mc_if #(.N(8), .NREGS(4), .Psize(5)) bus ();

   assign bus.imem_data = rom[bus.imem_addr];
   assign bus.in_data   = in_data;
   assign bus.in_valid  = in_valid;
   assign bus.out_ready = out_ready;

   pico_mips_mc #(.N(8), .NREGS(4), .Psize(5)) dut (
      .clk    (clk),
      .reset  (rst_n),
      .bus    (bus),
      .halted (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] enc(input opcode_t op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic iv, input logic [7:0] id, input logic orr);
      in_valid  = iv;
      in_data   = id;
      out_ready = orr;
   endtask

   // Leaves the bench at a negedge with reset asserted and at least one reset edge taken.
   task automatic hold_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 32; i++) rom[i] = enc(OP_JMP, 2'd0, 2'd0, 8'(i));
   endtask

   task automatic wait_out(input string name, input logic [7:0] exp);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      check_output({name, "_valid"}, bus.out_valid, 1);
      check_output({name, "_data"}, bus.out_data, exp);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_pc          = 5'd0;
      exp_out_data  = 8'h00;
      exp_out_valid = 1'b0;
      exp_in_ready  = 1'b0;
      exp_halted    = 1'b0;
      check_en      = 1'b1;
   endfunction

   task automatic mtick(output bit hit);
      @(posedge clk);
      hit = !rst_n;
      if (hit) model_reset();
   endtask

   // Model: one loop pass per instruction, a fetch edge then an execute edge,
   // plus however many edges an IN/OUT handshake takes. Any reset edge restarts it.
   initial begin : model
      bit          r;
      logic [14:0] ir;
      logic [2:0]  op;
      logic [1:0]  rd, rs;
      logic [7:0]  imm;
      int          a, b;
      forever begin
         mtick(r);
         if (r) continue;
         ir = rom[m_pc];
         mtick(r);
         if (r) continue;
         op  = ir[14:12];
         rd  = ir[11:10];
         rs  = ir[9:8];
         imm = ir[7:0];
         case (op)
            3'd0: begin m_regs[rd] = m_regs[rd] + m_regs[rs]; m_pc++; end
            3'd1: begin m_regs[rd] = m_regs[rd] + imm; m_pc++; end
            3'd2: begin
               a = $signed(m_regs[rd]);
               b = $signed(imm);
               m_regs[rd] = 8'((a * b) >>> 7);
               m_pc++;
            end
            3'd3: begin m_regs[rd] = m_regs[rd] - m_regs[rs]; m_pc++; end
            3'd4: begin
               exp_in_ready = 1'b1;
               exp_halted   = 1'b1;
               do mtick(r); while (!r && !in_valid);
               if (!r) begin
                  m_regs[rd]   = in_data;
                  m_pc++;
                  exp_in_ready = 1'b0;
                  exp_halted   = 1'b0;
               end
            end
            3'd5: begin
               exp_out_data  = m_regs[rd];
               exp_out_valid = 1'b1;
               exp_halted    = 1'b1;
               do mtick(r); while (!r && !out_ready);
               if (!r) begin
                  exp_out_valid = 1'b0;
                  exp_halted    = 1'b0;
                  m_pc++;
               end
            end
            3'd6: m_pc = (m_regs[rd] == 8'h00) ? imm[4:0] : 5'(m_pc + 5'd1);
            default: m_pc = imm[4:0];
         endcase
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (check_en) begin
         check_output("imem_addr", bus.imem_addr, m_pc);
         check_output("in_ready",  bus.in_ready,  exp_in_ready);
         check_output("out_valid", bus.out_valid, exp_out_valid);
         check_output("out_data",  bus.out_data,  exp_out_data);
         check_output("halted",    halted,        exp_halted);
      end
   end

   initial begin : main
      int cnt;

      // ALU sequence with reset-state pins
      hold_reset();
      clear_rom();
      rom[0] = enc(OP_ADDI, 2'd1, 2'd0, 8'd5);
      rom[1] = enc(OP_ADDI, 2'd2, 2'd0, 8'd3);
      rom[2] = enc(OP_ADD,  2'd1, 2'd2, 8'd0);
      rom[3] = enc(OP_OUT,  2'd1, 2'd0, 8'd0);
      rom[4] = enc(OP_JMP,  2'd0, 2'd0, 8'd4);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_output("rst_out_valid", bus.out_valid, 0);
      check_output("rst_imem_addr", bus.imem_addr, 0);
      check_output("rst_halted", halted, 0);
      check_output("rst_in_ready", bus.in_ready, 0);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      check_output("alu_c7_valid", bus.out_valid, 0);
      @(negedge clk);
      check_output("alu_c8_valid", bus.out_valid, 1);
      check_output("alu_c8_data", bus.out_data, 8'd8);
      @(negedge clk);
      check_output("alu_c9_valid", bus.out_valid, 0);
      check_output("alu_c9_data_kept", bus.out_data, 8'd8);

      // Reset while parked in WAIT_OUT
      hold_reset();
      apply_stimulus(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check_output("midrst_pre_valid", bus.out_valid, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      clear_rom();
      rom[0] = enc(OP_OUT, 2'd1, 2'd0, 8'd0);
      rom[1] = enc(OP_OUT, 2'd2, 2'd0, 8'd0);
      rom[2] = enc(OP_OUT, 2'd3, 2'd0, 8'd0);
      rom[3] = enc(OP_OUT, 2'd0, 2'd0, 8'd0);
      @(negedge clk);
      check_output("midrst_valid", bus.out_valid, 0);
      check_output("midrst_addr", bus.imem_addr, 0);
      check_output("midrst_halted", halted, 0);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_output("midrst_r1_valid", bus.out_valid, 1);
      check_output("midrst_r1_zero", bus.out_data, 0);
      repeat (12) @(negedge clk);

      // MULI in Q1.7
      hold_reset();
      clear_rom();
      rom[0] = enc(OP_ADDI, 2'd1, 2'd0, 8'h40);
      rom[1] = enc(OP_MULI, 2'd1, 2'd0, 8'h40);
      rom[2] = enc(OP_OUT,  2'd1, 2'd0, 8'h00);
      rom[3] = enc(OP_ADDI, 2'd2, 2'd0, 8'h80);
      rom[4] = enc(OP_MULI, 2'd2, 2'd0, 8'h80);
      rom[5] = enc(OP_OUT,  2'd2, 2'd0, 8'h00);
      rst_n = 1'b1;
      wait_out("muli_half", 8'h20);
      wait_out("muli_wrap", 8'h80);

      // IN stall
      hold_reset();
      clear_rom();
      rom[0] = enc(OP_IN,  2'd3, 2'd0, 8'd0);
      rom[1] = enc(OP_OUT, 2'd3, 2'd0, 8'd0);
      rom[2] = enc(OP_JMP, 2'd0, 2'd0, 8'd2);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            cnt++;
            if (cnt == 6) apply_stimulus(1'b1, 8'hA5, 1'b1);
         end else if (cnt > 0) begin
            check_output("in_halted_fall", halted, 0);
            apply_stimulus(1'b0, 8'h00, 1'b1);
            break;
         end
      end
      check_output("in_ready_cycles", cnt, 6);
      wait_out("in_r3", 8'hA5);

      // OUT back-pressure
      hold_reset();
      clear_rom();
      rom[0] = enc(OP_ADDI, 2'd2, 2'd0, 8'h77);
      rom[1] = enc(OP_OUT,  2'd2, 2'd0, 8'h00);
      rom[2] = enc(OP_JMP,  2'd0, 2'd0, 8'd2);
      apply_stimulus(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      wait_out("bp_first", 8'h77);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("bp_hold_data", bus.out_data, 8'h77);
         check_output("bp_hold_addr", bus.imem_addr, 1);
      end
      apply_stimulus(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      check_output("bp_accept_valid", bus.out_valid, 0);
      check_output("bp_accept_addr", bus.imem_addr, 2);

      // Branches and PC wrap
      hold_reset();
      clear_rom();
      rom[0]  = enc(OP_BZ,   2'd0, 2'd0, 8'h1E);
      rom[1]  = enc(OP_OUT,  2'd0, 2'd0, 8'h00);
      rom[2]  = enc(OP_JMP,  2'd0, 2'd0, 8'd2);
      rom[30] = enc(OP_ADDI, 2'd0, 2'd0, 8'd1);
      rom[31] = enc(OP_ADDI, 2'd2, 2'd0, 8'd2);
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 2) check_output("bz_taken", bus.imem_addr, 30);
         if (c == 4) check_output("pc_30_to_31", bus.imem_addr, 31);
         if (c == 6) check_output("pc_wrap", bus.imem_addr, 0);
         if (c == 8) check_output("bz_not_taken", bus.imem_addr, 1);
      end

      // Random programs with random channel behaviour and one mid-run reset each
      for (int p = 0; p < 3; p++) begin
         hold_reset();
         for (int i = 0; i < 32; i++) begin
            rom[i] = {3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 8'($urandom)};
         end
         rst_n = 1'b1;
         for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
            if (c == 250) rst_n = 1'b0;
            if (c == 252) rst_n = 1'b1;
         end
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
